// File: rtl/scmp_bus_responder.sv
// scmp_bus_responder: memory-side responder for an SC/MP-style external bus.
// Captures address and page nibble on NADS, then services one byte read or
// write to a local RAM. Each access is stretched by WAIT_STATES NHOLD cycles.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | no access in progress, waiting for NADS
// S_ARMED    | address latched, waiting for a read or write strobe
// S_RD_WAIT  | read accepted, counting wait states (NHOLD low while cnt!=0)
// S_WR_WAIT  | write accepted, counting wait states (NHOLD low while cnt!=0)
// S_RD_DRIVE | read data on db_out with db_oe high until NRDS is released
// S_WR_END   | write committed, waiting for NWDS to be released
module scmp_bus_responder #(
  parameter int         MEM_AW      = 8,
  parameter logic [3:0] PAGE        = 4'h0,
  parameter int         WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] addr,
  input  logic        nads,
  input  logic        nrds,
  input  logic        nwds,
  input  logic [7:0]  db_in,
  output logic [7:0]  db_out,
  output logic        db_oe,
  output logic        nhold,
  output logic        bus_err
);

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RD_WAIT,
    S_WR_WAIT,
    S_RD_DRIVE,
    S_WR_END
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] addr_lat;
  logic        sel_q;
  logic        latch_en;
  logic        err_d;
  logic        mem_we;
  logic        rd_load;

  logic [7:0]        mem [2**MEM_AW];
  logic [MEM_AW-1:0] mem_idx;

  // Upper address bits alias within the page; they are latched but never decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_lat;

  assign mem_idx = addr_lat[MEM_AW-1:0];

  // Wait request follows the counter directly so it releases in the cycle cnt hits 0.
  assign nhold = !(((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT)) && (cnt_q != 4'd0));

  // Next-state decode; NADS anywhere aborts the current access and relatches.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    err_d    = 1'b0;
    mem_we   = 1'b0;
    rd_load  = 1'b0;
    if (!nads) begin
      latch_en = 1'b1;
      state_d  = S_ARMED;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ARMED: begin
          if (sel_q) begin
            if (!nrds && !nwds) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else if (!nrds) begin
              cnt_d   = WS_LOAD;
              state_d = S_RD_WAIT;
            end else if (!nwds) begin
              cnt_d   = WS_LOAD;
              state_d = S_WR_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (nrds) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_q == 4'd0) begin
            rd_load = 1'b1;
            state_d = S_RD_DRIVE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_WR_WAIT: begin
          if (nwds) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_q == 4'd0) begin
            mem_we  = 1'b1;
            state_d = S_WR_END;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_RD_DRIVE: begin
          if (nrds) state_d = S_IDLE;
        end
        S_WR_END: begin
          if (nwds) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counter, address latch and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_lat <= 12'h000;
      sel_q    <= 1'b0;
      db_out   <= 8'h00;
      db_oe    <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bus_err <= err_d;
      db_oe   <= (state_d == S_RD_DRIVE);
      if (latch_en) begin
        addr_lat <= addr;
        sel_q    <= (db_in[3:0] == PAGE);
      end
      if (rd_load) db_out <= mem[mem_idx];
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= db_in;
  end

endmodule
